// File: rtl/sdi_xcvr_reconfig_pkg.sv
// Shared types and helpers for the SDI transceiver reconfig arbiter.
// Holds the FSM state encoding, grant ids and the RMW byte merge.
package sdi_xcvr_reconfig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_DONE   = 3'd5,
    ST_RDV    = 3'd6
  } state_e;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  // Byte lanes with their enable set take the new data, the rest keep the old word.
  function automatic logic [31:0] merge_bytes(input logic [3:0]  be,
                                              input logic [31:0] wdata,
                                              input logic [31:0] rdata);
    logic [31:0] merged;
    merged = rdata;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = wdata[8*i +: 8];
      end else begin
        merged[8*i +: 8] = rdata[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/sdi_xcvr_reconfig_arbiter.sv
// Round-robin arbiter between the PMA configurator (A) and a host master (B)
// onto the word-addressed reconfig mgmt slave, with RMW for partial writes.
module sdi_xcvr_reconfig_arbiter
  import sdi_xcvr_reconfig_pkg::*;
#(
  parameter int          ADDR_W  = 7,
  parameter int          TIMEOUT = 1023,
  parameter logic [31:0] TO_DATA = 32'hDEAD_BEEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_write_n,
  input  logic              a_read_n,
  input  logic [31:0]       a_address,
  input  logic [3:0]        a_byteenable,
  input  logic [31:0]       a_writedata,
  output logic [31:0]       a_readdata,
  output logic              a_readdatavalid,
  output logic              a_waitrequest,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [31:0]       b_writedata,
  output logic [31:0]       b_readdata,
  output logic              b_waitrequest,
  output logic              r_read,
  output logic              r_write,
  output logic [ADDR_W-1:0] r_address,
  output logic [31:0]       r_writedata,
  input  logic [31:0]       r_readdata,
  input  logic              r_waitrequest,
  input  logic              timeout_clr,
  output logic              timeout_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                last_q, last_d;
  logic                op_rd_q, op_rd_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         a_rdata_q, a_rdata_d;
  logic [31:0]         b_rdata_q, b_rdata_d;
  logic                terr_q, terr_d;
  logic                r_read_q, r_write_q, a_wait_q, b_wait_q, a_rdv_q, busy_q;
  logic                req_a_s, req_b_s, to_set_s;
  logic                unused_addr_s;

  assign req_a_s       = !a_read_n || !a_write_n;
  assign req_b_s       = b_read || b_write;
  assign unused_addr_s = ^{a_address[31:ADDR_W+2], a_address[1:0]};

  // Next-state, grant latching, downstream completion and timeout handling.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    op_rd_d   = op_rd_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    to_set_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_a_s || req_b_s) begin
          gnt_d  = (req_a_s && (!req_b_s || last_q == GNT_B)) ? GNT_A : GNT_B;
          last_d = gnt_d;
          cnt_d  = '0;
          if (gnt_d == GNT_A) begin
            op_rd_d = !a_read_n;
            addr_d  = a_address[ADDR_W+1:2];
            wdata_d = a_writedata;
            be_d    = a_byteenable;
          end else begin
            op_rd_d = b_read;
            addr_d  = b_address;
            wdata_d = b_writedata;
            be_d    = 4'hF;
          end
          if (op_rd_d) begin
            state_d = ST_RD;
          end else if (be_d == 4'hF) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RMW_RD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD, ST_WR, ST_RMW_RD, ST_RMW_WR: begin
        if (!r_waitrequest) begin
          cnt_d = '0;
          case (state_q)
            ST_RD: begin
              if (gnt_q == GNT_A) begin
                a_rdata_d = r_readdata;
              end else begin
                b_rdata_d = r_readdata;
              end
              state_d = ST_DONE;
            end
            ST_RMW_RD: begin
              wdata_d = merge_bytes(be_q, wdata_q, r_readdata);
              state_d = ST_RMW_WR;
            end
            default: state_d = ST_DONE;
          endcase
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Abort: drop the strobe, skip any pending RMW write phase.
          to_set_s = 1'b1;
          cnt_d    = '0;
          state_d  = ST_DONE;
          if (gnt_q == GNT_A) begin
            a_rdata_d = TO_DATA;
          end else begin
            b_rdata_d = TO_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (gnt_q == GNT_A && op_rd_q) begin
          state_d = ST_RDV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RDV:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (to_set_s) begin
      terr_d = 1'b1;
    end else if (timeout_clr) begin
      terr_d = 1'b0;
    end else begin
      terr_d = terr_q;
    end
  end

  // State, latched request and registered outputs decoded from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= GNT_B;
      last_q    <= GNT_B;
      op_rd_q   <= 1'b0;
      be_q      <= 4'h0;
      wdata_q   <= 32'h0;
      addr_q    <= '0;
      cnt_q     <= '0;
      a_rdata_q <= 32'h0;
      b_rdata_q <= 32'h0;
      terr_q    <= 1'b0;
      r_read_q  <= 1'b0;
      r_write_q <= 1'b0;
      a_wait_q  <= 1'b1;
      b_wait_q  <= 1'b1;
      a_rdv_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      op_rd_q   <= op_rd_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      terr_q    <= terr_d;
      r_read_q  <= (state_d == ST_RD) || (state_d == ST_RMW_RD);
      r_write_q <= (state_d == ST_WR) || (state_d == ST_RMW_WR);
      a_wait_q  <= !((state_d == ST_DONE) && (gnt_d == GNT_A));
      b_wait_q  <= !((state_d == ST_DONE) && (gnt_d == GNT_B));
      a_rdv_q   <= (state_d == ST_RDV);
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign a_readdata      = a_rdata_q;
  assign a_readdatavalid = a_rdv_q;
  assign a_waitrequest   = a_wait_q;
  assign b_readdata      = b_rdata_q;
  assign b_waitrequest   = b_wait_q;
  assign r_read          = r_read_q;
  assign r_write         = r_write_q;
  assign r_address       = addr_q;
  assign r_writedata     = wdata_q;
  assign timeout_err     = terr_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_sdi_xcvr_reconfig_arbiter.sv
// Bench: directed scenarios plus random two-master traffic against a
// behavioural memory model of the reconfig slave.
module tb_sdi_xcvr_reconfig_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        a_write_n, a_read_n;
  logic [31:0] a_address, a_writedata, a_readdata;
  logic [3:0]  a_byteenable;
  logic        a_readdatavalid, a_waitrequest;
  logic        b_read, b_write, b_waitrequest;
  logic [6:0]  b_address;
  logic [31:0] b_writedata, b_readdata;
  logic        r_read, r_write, r_waitrequest;
  logic [6:0]  r_address;
  logic [31:0] r_writedata, r_readdata;
  logic        timeout_clr, timeout_err, busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mem     [0:127];
  logic [31:0] ref_mem [0:127];
  int          slv_mode = 0;
  int          stall_left = 0;
  int          hi_run = 0;
  int          rd_acc = 0, wr_acc = 0;
  logic [31:0] last_wr_data = 32'h0;
  logic [6:0]  last_wr_addr = 7'h0;
  bit          order_q[$];

  sdi_xcvr_reconfig_arbiter #(.ADDR_W(7), .TIMEOUT(15), .TO_DATA(32'hDEAD_BEEF)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_write_n(a_write_n), .a_read_n(a_read_n), .a_address(a_address),
    .a_byteenable(a_byteenable), .a_writedata(a_writedata), .a_readdata(a_readdata),
    .a_readdatavalid(a_readdatavalid), .a_waitrequest(a_waitrequest),
    .b_read(b_read), .b_write(b_write), .b_address(b_address),
    .b_writedata(b_writedata), .b_readdata(b_readdata), .b_waitrequest(b_waitrequest),
    .r_read(r_read), .r_write(r_write), .r_address(r_address),
    .r_writedata(r_writedata), .r_readdata(r_readdata), .r_waitrequest(r_waitrequest),
    .timeout_clr(timeout_clr), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clock = ~clock;

  // Slave read data is only meaningful in the accepting cycle; poison it otherwise.
  assign r_readdata = (r_read && !r_waitrequest) ? mem[r_address] : 32'hBAD0_BAD0;

  always @(negedge clock) begin
    case (slv_mode)
      1: begin
        if (hi_run >= 3) r_waitrequest = 1'b0;
        else r_waitrequest = ($urandom_range(0, 2) == 0);
        hi_run = r_waitrequest ? hi_run + 1 : 0;
      end
      2: begin
        if ((r_read || r_write) && stall_left > 0) begin
          r_waitrequest = 1'b1;
          stall_left    = stall_left - 1;
        end else begin
          r_waitrequest = 1'b0;
        end
      end
      3:       r_waitrequest = 1'b1;
      default: r_waitrequest = 1'b0;
    endcase
  end

  always @(posedge clock) begin
    if (r_write && !r_waitrequest) begin
      mem[r_address] <= r_writedata;
      last_wr_data   <= r_writedata;
      last_wr_addr   <= r_address;
      wr_acc         <= wr_acc + 1;
    end
    if (r_read && !r_waitrequest) rd_acc <= rd_acc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tb_merge(input logic [3:0] be, input logic [31:0] nw,
                                           input logic [31:0] old);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) if (be[i]) res[8*i +: 8] = nw[8*i +: 8];
    return res;
  endfunction

  task automatic a_idle();
    a_read_n  = 1'b1;
    a_write_n = 1'b1;
  endtask

  task automatic b_idle();
    b_read  = 1'b0;
    b_write = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting one.
  task automatic a_op(input bit rd, input logic [6:0] wa, input logic [3:0] be,
                      input logic [31:0] wd, output int n);
    logic [31:0] addr;
    logic [31:0] exp_v;
    exp_v = 32'h0;
    addr = $urandom;
    addr[8:2] = wa;
    a_address    = addr;
    a_byteenable = be;
    a_writedata  = wd;
    a_read_n     = !rd;
    a_write_n    = rd ? 1'($urandom_range(0, 1)) : 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (a_waitrequest && n < 400);
    if (a_waitrequest) begin
      check_eq("a_wait_bound", 32'd1, 32'd0);
      return;
    end
    if (rd) exp_v = ref_mem[wa];
    else ref_mem[wa] = tb_merge(be, wd, ref_mem[wa]);
    order_q.push_back(1'b0);
    @(negedge clock);
    check_eq("a_wait_hi_after", a_waitrequest, 32'd1);
    check_eq("a_rdv", a_readdatavalid, rd);
    if (rd) check_eq("a_rdata", a_readdata, exp_v);
  endtask

  task automatic b_op(input bit rd, input logic [6:0] wa, input logic [31:0] wd, output int n);
    b_address   = wa;
    b_writedata = wd;
    b_read      = rd;
    b_write     = rd ? 1'($urandom_range(0, 1)) : 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (b_waitrequest && n < 400);
    if (b_waitrequest) begin
      check_eq("b_wait_bound", 32'd1, 32'd0);
      return;
    end
    if (rd) check_eq("b_rdata", b_readdata, ref_mem[wa]);
    else ref_mem[wa] = wd;
    order_q.push_back(1'b1);
    @(negedge clock);
    check_eq("b_wait_hi_after", b_waitrequest, 32'd1);
  endtask

  initial begin
    int n, rd0, wr0, cnt;
    bit exp_order[4];
    reset_n = 1'b0;
    timeout_clr = 1'b0;
    r_waitrequest = 1'b0;
    a_address = 32'h0; a_byteenable = 4'h0; a_writedata = 32'h0;
    b_address = 7'h0; b_writedata = 32'h0;
    a_idle(); b_idle();
    for (int i = 0; i < 128; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clock);
    check_eq("rst_a_wait", a_waitrequest, 32'd1);
    check_eq("rst_b_wait", b_waitrequest, 32'd1);
    check_eq("rst_strobes", {r_read, r_write, a_readdatavalid, busy, timeout_err}, 32'd0);
    check_eq("rst_r_addr", r_address, 32'd0);
    check_eq("rst_r_wdata", r_writedata, 32'd0);
    check_eq("rst_rdata", a_readdata | b_readdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Round robin: both request together, A twice, B twice.
    order_q.delete();
    fork
      begin a_op(1'b0, 7'd20, 4'hF, 32'h0A0A_0001, n); a_op(1'b0, 7'd21, 4'hF, 32'h0A0A_0002, n); a_idle(); end
      begin b_op(1'b0, 7'd22, 32'h0B0B_0001, n); b_op(1'b0, 7'd23, 32'h0B0B_0002, n); b_idle(); end
    join
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
    check_eq("rr_count", order_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < order_q.size(); i++) check_eq("rr_order", order_q[i], exp_order[i]);
    @(negedge clock);

    // Full write, no downstream stall.
    rd0 = rd_acc; wr0 = wr_acc;
    a_op(1'b0, 7'h10, 4'hF, 32'h1234_5678, n);
    a_idle();
    check_eq("wr_latency", n, 32'd2);
    check_eq("wr_count", wr_acc - wr0, 32'd1);
    check_eq("wr_no_read", rd_acc - rd0, 32'd0);
    check_eq("wr_addr", last_wr_addr, 32'h10);
    check_eq("wr_data", last_wr_data, 32'h1234_5678);

    // Read with three stall cycles.
    mem[2] = 32'hCAFE_0001; ref_mem[2] = 32'hCAFE_0001;
    stall_left = 3; slv_mode = 2;
    @(negedge clock);
    a_op(1'b1, 7'd2, 4'hF, 32'h0, n);
    a_idle();
    check_eq("rd_stall_latency", n, 32'd5);

    // Partial write turns into read-modify-write.
    slv_mode = 0;
    mem[5] = 32'h1122_3344; ref_mem[5] = 32'h1122_3344;
    @(negedge clock);
    rd0 = rd_acc; wr0 = wr_acc;
    a_op(1'b0, 7'd5, 4'b0101, 32'hAABB_CCDD, n);
    a_idle();
    check_eq("rmw_latency", n, 32'd3);
    check_eq("rmw_reads", rd_acc - rd0, 32'd1);
    check_eq("rmw_writes", wr_acc - wr0, 32'd1);
    check_eq("rmw_data", last_wr_data, 32'h11BB_33DD);
    check_eq("rmw_addr", last_wr_addr, 32'd5);

    // B read times out against a stuck slave.
    slv_mode = 3;
    @(negedge clock);
    b_address = 7'd9; b_read = 1'b1; b_write = 1'b0;
    n = 0; cnt = 0;
    do begin @(negedge clock); n++; if (r_read) cnt++; end while (b_waitrequest && n < 100);
    check_eq("to_wait_seen", b_waitrequest, 32'd0);
    check_eq("to_stall_cycles", cnt, 32'd15);
    check_eq("to_rdata", b_readdata, 32'hDEAD_BEEF);
    check_eq("to_err_set", timeout_err, 32'd1);
    @(negedge clock);
    b_idle(); slv_mode = 0;
    check_eq("to_strobe_off", r_read, 32'd0);
    repeat (3) @(negedge clock);
    check_eq("to_err_sticky", timeout_err, 32'd1);
    timeout_clr = 1'b1;
    @(negedge clock);
    timeout_clr = 1'b0;
    check_eq("to_err_clr", timeout_err, 32'd0);

    // Reset in the middle of an RMW read phase.
    slv_mode = 3;
    @(negedge clock);
    a_address = 32'h0000_000C; a_byteenable = 4'b0011; a_writedata = 32'h5555_6666;
    a_read_n = 1'b1; a_write_n = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("mid_r_read", r_read, 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_strobes", {r_read, r_write, busy}, 32'd0);
    check_eq("mid_rst_a_wait", a_waitrequest, 32'd1);
    a_idle(); slv_mode = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_eq("mid_no_write", mem[3], ref_mem[3]);
    a_op(1'b1, 7'd3, 4'hF, 32'h0, n);
    a_idle();
    check_eq("mid_rd_latency", n, 32'd2);

    // Random two-master traffic against the memory model.
    slv_mode = 1;
    @(negedge clock);
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          int na;
          logic [3:0] be;
          be = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
          a_op(1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), be, $urandom, na);
          a_idle();
          repeat ($urandom_range(0, 2)) @(negedge clock);
        end
      end
      begin
        for (int j = 0; j < 40; j++) begin
          int nb;
          b_op(1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), $urandom, nb);
          b_idle();
          repeat ($urandom_range(0, 2)) @(negedge clock);
        end
      end
    join
    slv_mode = 0;
    repeat (4) @(negedge clock);
    for (int k = 0; k < 8; k++) check_eq("mem_final", mem[k], ref_mem[k]);
    check_eq("final_idle", busy, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
